// File: rtl/mul_div_if.sv
// Issue/response bundle between the datapath (master) and the iterative
// RV32M multiply/divide unit (slave).
interface mul_div_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT_LENGTH = 3
);
    logic                    Start;
    logic [FUNCT_LENGTH-1:0] Funct3;
    logic [DATA_WIDTH-1:0]   SrcA;
    logic [DATA_WIDTH-1:0]   SrcB;
    logic                    Busy;
    logic                    Done;
    logic [DATA_WIDTH-1:0]   Result;

    modport master (output Start, Funct3, SrcA, SrcB, input Busy, Done, Result);
    modport slave  (input Start, Funct3, SrcA, SrcB, output Busy, Done, Result);
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative RV32M multiply/divide: shift-add multiply, restoring divide.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divide ops return 0.
module mul_div_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT_LENGTH = 3
) (
    input logic       clk,
    input logic       reset,
    mul_div_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [FUNCT_LENGTH-1:0] op_q;
    logic [W-1:0]            mag_q;
    logic [2*W-1:0]          acc_q;
    logic                    neg_q;
    logic                    spec_q;
    logic [W-1:0]            spec_res_q;
    logic                    busy_q;
    logic                    done_q;
    logic [W-1:0]            result_q;

    logic           is_div, a_signed, b_signed, a_neg, b_neg, neg_d;
    logic [W-1:0]   a_mag, b_mag;
    logic           special_d;
    logic [W-1:0]   spec_res_d;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_acc_d;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   res_d;

    always_comb begin
        is_div   = bus.Funct3[2];
        // MULH/MULHSU/DIV/REM treat rs1 as signed; only MULH/DIV/REM treat rs2 as signed
        a_signed = is_div ? !bus.Funct3[0] : (bus.Funct3[1:0] == 2'b01 || bus.Funct3[1:0] == 2'b10);
        b_signed = is_div ? !bus.Funct3[0] : (bus.Funct3[1:0] == 2'b01);
        a_neg    = a_signed & bus.SrcA[W-1];
        b_neg    = b_signed & bus.SrcB[W-1];
        a_mag    = a_neg ? -bus.SrcA : bus.SrcA;
        b_mag    = b_neg ? -bus.SrcB : bus.SrcB;
        neg_d    = (is_div && bus.Funct3[1]) ? a_neg : (a_neg ^ b_neg);
    end

`ifdef MULDIV_DIV_EN
    logic [W-1:0] rem_q;
    logic [W-1:0] rem_d;
    logic [W-1:0] quot_d;
    logic [W:0]   rem_sh;
    logic [W:0]   diff;
    logic         div_zero, div_ovf;

    always_comb begin
        div_zero   = (bus.SrcB == '0);
        div_ovf    = !bus.Funct3[0] && (bus.SrcA == {1'b1, {(W-1){1'b0}}}) && (bus.SrcB == '1);
        special_d  = is_div && (div_zero || div_ovf);
        spec_res_d = '0;
        if (div_zero)
            spec_res_d = bus.Funct3[1] ? bus.SrcA : '1;
        else if (div_ovf)
            spec_res_d = bus.Funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};

        // rem < divisor before the shift, so the difference fits in W+1 bits and bit W flags a borrow
        rem_sh = {rem_q, acc_q[W-1]};
        diff   = rem_sh - {1'b0, mag_q};
        if (!diff[W]) begin
            rem_d  = diff[W-1:0];
            quot_d = {acc_q[W-2:0], 1'b1};
        end else begin
            rem_d  = rem_sh[W-1:0];
            quot_d = {acc_q[W-2:0], 1'b0};
        end
    end
`else
    always_comb begin
        special_d  = is_div;
        spec_res_d = '0;
    end
`endif

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        mul_acc_d = {mul_sum, acc_q[W-1:1]};
        // High-half sign correction must negate the full double-width product
        prod_fix  = neg_q ? -acc_q : acc_q;
        res_d     = '0;
        if (spec_q)
            res_d = spec_res_q;
        else if (!op_q[2])
            res_d = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
`ifdef MULDIV_DIV_EN
        else if (op_q[1])
            res_d = neg_q ? -rem_q : rem_q;
        else
            res_d = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            mag_q      <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
`ifdef MULDIV_DIV_EN
            rem_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        op_q       <= bus.Funct3;
                        neg_q      <= neg_d;
                        cnt_q      <= '0;
                        spec_q     <= special_d;
                        spec_res_q <= spec_res_d;
                        // Multiply keeps the multiplicand aside; divide keeps the divisor
                        mag_q      <= is_div ? b_mag : a_mag;
                        acc_q      <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
`ifdef MULDIV_DIV_EN
                        rem_q      <= '0;
`endif
                        busy_q     <= 1'b1;
                        state_q    <= special_d ? FINISH : CALC;
                    end
                end
                CALC: begin
`ifdef MULDIV_DIV_EN
                    if (op_q[2]) begin
                        acc_q <= {acc_q[2*W-1:W], quot_d};
                        rem_q <= rem_d;
                    end else begin
                        acc_q <= mul_acc_d;
                    end
`else
                    acc_q <= mul_acc_d;
`endif
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W-1))
                        state_q <= FINISH;
                end
                FINISH: begin
                    result_q <= res_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Result = result_q;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit. It is the multi-cycle counterpart to the single-cycle ALU, covering the M-extension operations the ALU does not implement.
- The datapath issues an operation with a one-cycle Start pulse, stalls while Busy is high, and captures Result when Done pulses.
- Radix-2: one bit per cycle, using shift-add for multiply and restoring division for divide.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- FUNCT_LENGTH, 3, operation select width (RV32M funct3 encoding).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Funct3  input  FUNCT_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  DATA_WIDTH  rs1 operand (multiplicand/dividend).
- SrcB  input  DATA_WIDTH  rs2 operand (multiplier/divisor).
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse: Result valid.
- Result  output  DATA_WIDTH  registered result, held until the next Done.

Behaviour:
- Reset (synchronous, active-high; dominates every other input): state=IDLE, Busy=0, Done=0, Result=0, counter=0, internal registers cleared.
- Reset asserted mid-operation aborts it with no Done and no Result update.
- States: IDLE, CALC, FINISH.
- IDLE:
  - Start=1 at edge E0 latches Funct3, SrcA and SrcB.
  - Signed ops take operand magnitudes and record the result sign. MULHSU: SrcA signed, SrcB unsigned. MULHU/DIVU/REMU: both unsigned.
  - Counter cleared; go to CALC, except for the special cases below, which go to FINISH.
- CALC:
  - One iteration per edge.
  - Multiply: 2*DATA_WIDTH-bit product accumulator.
  - Divide: DATA_WIDTH+1-bit partial remainder, restoring step.
  - After the iteration at counter==DATA_WIDTH-1 (edge E_DATA_WIDTH), go to FINISH.
- FINISH:
  - Apply sign correction.
  - Select the output: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register Result and set Done=1 at the next edge; return to IDLE.
- Normal latency: Start edge E0 to Done high after edge E(DATA_WIDTH+1), i.e. 33 edges for width 32.
- Busy is high in the cycles following E0 through E_DATA_WIDTH. Busy=0 whenever Done=1.
- Done is high for exactly one cycle, cleared at the next edge unconditionally.
- Sign rules:
  - Quotient is negated when the operand signs differ (signed DIV).
  - Remainder takes the sign of the dividend (REM).
  - Signed high-product is negated as a full 2*DATA_WIDTH value before the high half is taken.
- Special cases (fast path: IDLE -> FINISH, Done after E1, Busy high one cycle):
  - Divisor==0: DIV/DIVU quotient = all ones; REM/REMU = SrcA unchanged.
  - Signed overflow (SrcA = most-negative, SrcB = -1): DIV = most-negative value; REM = 0.
  - MUL-family with either operand == 0 is not a special case; it takes the normal latency.
- Start while Busy: ignored; operands and Funct3 are not re-latched.
- Start in the same cycle Done is high (state IDLE): accepted (back-to-back issue). The previous Result holds until the new Done.
- Operand changes after E0 have no effect.

Optional Feature:
- Macro: MULDIV_DIV_EN.
- Defined: all eight operations supported as described.
- Undefined: divide datapath (remainder register, restoring step) is not synthesized. Funct3[2]=1 requests take the fast path with Result=0 and Done after E1. Multiply behaviour is unchanged.

Test Plan:
- Multiply: MUL SrcA=7, SrcB=0xFFFFFFFD -> Result=0xFFFFFFEB, Done exactly once, 33 edges after Start; Busy low during Done. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Special cases:
  - DIVU 5 / 0 -> 0xFFFFFFFF, and REMU 5 / 0 -> 5, each with Done after 2 edges.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM -> 0, each fast path.
- Handshake: Start held high for 10 cycles mid-operation with changing SrcA -> first request's result only, single Done. New Start in the Done cycle -> second result after a further 33 edges.
- Reset mid-CALC: reset at edge 12 -> Busy=0, Done=0, Result=0 next cycle, no Done ever for the aborted op. Next request completes normally.
- Macro off: DIV 100 / 7 -> Result=0, Done after 2 edges. MUL 6 x 7 -> 42 unchanged.
